wptr_full_ctrl: RTL and testbench

//  Write-domain pointer and full-flag controller for the dual-clock FIFO.
//  - Keeps the binary write address and publishes the Gray-coded write pointer.
//    The read-clock two-flop synchronizer carries that pointer into the read domain.
//  - Takes the read pointer after it has been synchronized into the write domain.
//  - From those two pointers it generates full, almost-full, fill level and a sticky overflow flag.

---
 rtl/fifo_pkg.sv | 29 ++
 rtl/gray2bin_conv.sv | 20 ++
 rtl/wptr_full_ctrl.sv | 95 +++++++++
 tb/tb_wptr_full_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared pointer sizing, types and Gray helpers for both
//                domains of the dual-clock FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int FIFO_PTR_WIDTH = 4;
    localparam int DEPTH          = 1 << FIFO_PTR_WIDTH;

    typedef logic [FIFO_PTR_WIDTH:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t bin);
        return (bin >> 1) ^ bin;
    endfunction

    function automatic ptr_t gray2bin(input ptr_t gray);
        ptr_t bin;
        bin = '0;
        for (int i = 0; i <= FIFO_PTR_WIDTH; i++) begin
            bin[i] = ^(gray >> i);
        end
        return bin;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gray2bin_conv.sv
`default_nettype none
// ============================================================================
//  Module      : gray2bin_conv
//  Description : Combinational parameterised Gray-to-binary converter.
//  Revision    : 1.0 - initial release
// ============================================================================
module gray2bin_conv #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    // Each binary bit is the XOR of all Gray bits at or above it.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin[i] = ^(gray >> i);
    end

endmodule
`default_nettype wire

// File: rtl/wptr_full_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : wptr_full_ctrl
//  Description : Write-domain pointer, full/almost-full, level and sticky
//                overflow controller for the dual-clock FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module wptr_full_ctrl
    import fifo_pkg::*;
#(
    parameter int PTR_WIDTH = 4,
    parameter int AF_MARGIN = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 winc,
    input  logic [PTR_WIDTH:0]   wq2_rptr,
    input  logic                 clr_ovf,
    output logic [PTR_WIDTH-1:0] waddr,
    output logic [PTR_WIDTH:0]   wptr,
    output logic                 wfull,
    output logic                 walmost_full,
    output logic [PTR_WIDTH:0]   wlevel,
    output logic                 woverflow
);

    localparam int               c_DEPTH     = 1 << PTR_WIDTH;
    localparam logic [PTR_WIDTH:0] c_AF_THRESH = (PTR_WIDTH+1)'(c_DEPTH - AF_MARGIN);

    logic [PTR_WIDTH:0] r_bin;
    logic [PTR_WIDTH:0] r_gray;
    logic               r_full;
    logic               r_afull;
    logic [PTR_WIDTH:0] r_level;
    logic               r_ovf;

    logic               w_wen;
    logic [PTR_WIDTH:0] w_bin_nxt;
    logic [PTR_WIDTH:0] w_gray_nxt;
    logic [PTR_WIDTH:0] w_rbin;
    logic [PTR_WIDTH:0] w_level_nxt;
    logic [PTR_WIDTH:0] w_rptr_full;
    logic               w_full_nxt;
    logic               w_afull_nxt;

    gray2bin_conv #(
        .WIDTH (PTR_WIDTH + 1)
    ) u_rptr_conv (
        .gray (wq2_rptr),
        .bin  (w_rbin)
    );

    assign w_wen       = winc & ~r_full;
    assign w_bin_nxt   = r_bin + {{PTR_WIDTH{1'b0}}, w_wen};
    assign w_gray_nxt  = (w_bin_nxt >> 1) ^ w_bin_nxt;
    assign w_level_nxt = w_bin_nxt - w_rbin;

    // Full when the write pointer has lapped the read pointer exactly once:
    // in Gray code that means the top two bits are inverted, the rest equal.
    assign w_rptr_full = {~wq2_rptr[PTR_WIDTH:PTR_WIDTH-1], wq2_rptr[PTR_WIDTH-2:0]};
    assign w_full_nxt  = (w_gray_nxt == w_rptr_full);
    assign w_afull_nxt = (w_level_nxt >= c_AF_THRESH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin   <= '0;
            r_gray  <= '0;
            r_full  <= 1'b0;
            r_afull <= 1'b0;
            r_level <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_bin   <= w_bin_nxt;
            r_gray  <= w_gray_nxt;
            r_full  <= w_full_nxt;
            r_afull <= w_afull_nxt;
            r_level <= w_level_nxt;
            // A dropped write outranks a concurrent clear.
            if (winc && r_full) begin
                r_ovf <= 1'b1;
            end else if (clr_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign waddr        = r_bin[PTR_WIDTH-1:0];
    assign wptr         = r_gray;
    assign wfull        = r_full;
    assign walmost_full = r_afull;
    assign wlevel       = r_level;
    assign woverflow    = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_wptr_full_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wptr_full_ctrl
//  Description : Scoreboard bench for wptr_full_ctrl against a write/read
//                counter model of the FIFO occupancy.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wptr_full_ctrl;

    localparam int c_PW    = 4;
    localparam int c_DEPTH = 16;
    localparam int c_AFM   = 2;

    typedef struct packed {
        logic [3:0] waddr;
        logic [4:0] wptr;
        logic       full;
        logic       afull;
        logic [4:0] level;
        logic       ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       winc;
    logic [4:0] wq2_rptr;
    logic       clr_ovf;
    logic [3:0] waddr;
    logic [4:0] wptr;
    logic       wfull;
    logic       walmost_full;
    logic [4:0] wlevel;
    logic       woverflow;

    exp_t q[$];
    int   vectors    = 0;
    int   miscompares = 0;

    // Model state: total accepted writes, reader position, sticky overflow.
    int   wcnt = 0;
    int   rcnt = 0;
    int   exp_level = 0;
    bit   m_ovf = 1'b0;
    bit   saw_reset = 1'b1;

    wptr_full_ctrl #(
        .PTR_WIDTH (c_PW),
        .AF_MARGIN (c_AFM)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .winc         (winc),
        .wq2_rptr     (wq2_rptr),
        .clr_ovf      (clr_ovf),
        .waddr        (waddr),
        .wptr         (wptr),
        .wfull        (wfull),
        .walmost_full (walmost_full),
        .wlevel       (wlevel),
        .woverflow    (woverflow)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] to_gray(input int n);
        logic [4:0] b;
        b = 5'(n % 32);
        return b ^ (b >> 1);
    endfunction

    task automatic push_zero();
        q.push_back('0);
    endtask

    task automatic step(input logic wi, input logic cl, input int rc);
        bit   full_prev;
        exp_t e;
        @(negedge clk);
        winc     = wi;
        clr_ovf  = cl;
        rcnt     = rc;
        wq2_rptr = to_gray(rc);
        full_prev = (exp_level == c_DEPTH);
        if (wi && !full_prev) wcnt++;
        if (wi && full_prev) m_ovf = 1'b1;
        else if (cl)         m_ovf = 1'b0;
        exp_level = wcnt - rcnt;
        e.waddr = 4'(wcnt % c_DEPTH);
        e.wptr  = to_gray(wcnt);
        e.full  = (exp_level == c_DEPTH);
        e.afull = (exp_level >= c_DEPTH - c_AFM);
        e.level = 5'(exp_level);
        e.ovf   = m_ovf;
        q.push_back(e);
    endtask

    // Drops rst_n between clock edges; outputs must clear before the next edge.
    task automatic async_reset();
        @(negedge clk);
        #2;
        push_zero();
        push_zero();
        rst_n = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        wcnt = 0;
        rcnt = 0;
        exp_level = 0;
        m_ovf = 1'b0;
    endtask

    // Monitor: every edge that can change an output pops one expectation.
    initial begin
        exp_t       e;
        logic [4:0] prev_wptr;
        prev_wptr = '0;
        forever begin
            @(posedge clk or negedge rst_n);
            #1;
            if (!rst_n) saw_reset = 1'b1;
            if (q.size() != 0) begin
                e = q.pop_front();
                vectors++;
                if (waddr !== e.waddr || wptr !== e.wptr || wfull !== e.full ||
                    walmost_full !== e.afull || wlevel !== e.level || woverflow !== e.ovf) begin
                    miscompares++;
                    $display("FAIL outputs t=%0t got waddr=%0d wptr=%b full=%b af=%b level=%0d ovf=%b want waddr=%0d wptr=%b full=%b af=%b level=%0d ovf=%b",
                             $time, waddr, wptr, wfull, walmost_full, wlevel, woverflow,
                             e.waddr, e.wptr, e.full, e.afull, e.level, e.ovf);
                end
                if (!saw_reset) begin
                    vectors++;
                    if ($countones(wptr ^ prev_wptr) > 1) begin
                        miscompares++;
                        $display("FAIL wptr_hamming t=%0t got %b after %b want <=1 bit change",
                                 $time, wptr, prev_wptr);
                    end
                end
                saw_reset = !rst_n;
                prev_wptr = wptr;
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        winc     = 1'b1;
        clr_ovf  = 1'b0;
        wq2_rptr = '0;

        // Held in reset with winc asserted.
        repeat (3) begin
            @(negedge clk);
            push_zero();
        end
        @(posedge clk);
        #3;
        rst_n = 1'b1;

        // First write, then fill to full.
        step(1'b1, 1'b0, 0);
        repeat (15) step(1'b1, 1'b0, 0);

        // Overflow and clear priority.
        repeat (3) step(1'b1, 1'b0, 0);
        step(1'b0, 1'b1, 0);
        step(1'b1, 1'b1, 0);
        step(1'b0, 1'b0, 0);

        // Drain as seen through the synchronized read pointer.
        step(1'b0, 1'b0, 1);
        step(1'b0, 1'b0, 2);

        // Wrap with a reader trailing three behind.
        async_reset();
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b0, (wcnt >= 3) ? wcnt - 3 : 0);
        end

        // Reset in the middle of a fill, then refill past full.
        async_reset();
        repeat (9) step(1'b1, 1'b0, 0);
        async_reset();
        repeat (18) step(1'b1, 1'b0, 0);

        // Randomised producer, reader and clears.
        async_reset();
        for (int i = 0; i < 400; i++) begin
            int rc;
            rc = rcnt;
            if (wcnt > rcnt && ($urandom % 3) == 0) rc = rcnt + 1;
            step(($urandom % 4) != 0, ($urandom % 16) == 0, rc);
        end

        step(1'b0, 1'b0, rcnt);
        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
        #2;
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain got %0d pending want 0", q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
